// File: rtl/timer_bank.sv
// Bank of independent countdown timers sharing one prescaler. Each channel
// is loaded/configured through a shared bus addressed by ch_select, raises a
// sticky pending flag on expiry, and the bank reports the lowest pending
// channel as an interrupt source.
// DATA_WIDTH must be at least 2 because the mode word uses DATA[1:0].

// One countdown channel: count/reload registers, enable and auto-reload bits,
// pending flag and IDLE/RUNNING/EXPIRED state.
module timer_bank_ch #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  tick_i,
    input  logic                  load_i,
    input  logic                  mode_i,
    input  logic                  ack_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic [DATA_WIDTH-1:0] count_o,
    output logic                  timeout_o,
    output logic                  pending_o
);
    typedef enum logic [1:0] {IDLE, RUNNING, EXPIRED} state_e;

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] count_q, count_d;
    logic [DATA_WIDTH-1:0] reload_q, reload_d;
    logic                  en_q, en_d;
    logic                  ar_q, ar_d;
    logic                  pend_q, pend_d;
    logic                  step;
    logic                  last;

    // A running, enabled channel consumes a tick; count==1 is the final tick.
    assign step = tick_i & en_q & (state_q == RUNNING);
    assign last = step & (count_q == DATA_WIDTH'(1));

    // Next-state: load beats mode write and expiry; a new expiry beats ack.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        en_d     = en_q;
        ar_d     = ar_q;
        pend_d   = pend_q;
        if (load_i) begin
            count_d  = data_i;
            reload_d = data_i;
            pend_d   = 1'b0;
            state_d  = (data_i != '0) ? RUNNING : EXPIRED;
        end else begin
            if (mode_i) begin
                en_d = data_i[0];
                ar_d = data_i[1];
            end
            if (last) begin
                if (ar_q) begin
                    count_d = reload_q;
                end else begin
                    count_d = '0;
                    state_d = EXPIRED;
                end
            end else if (step && count_q > DATA_WIDTH'(1)) begin
                count_d = count_q - DATA_WIDTH'(1);
            end
            pend_d = last | (pend_q & ~ack_i);
        end
    end

    // Channel registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            count_q  <= '0;
            reload_q <= '0;
            en_q     <= 1'b0;
            ar_q     <= 1'b0;
            pend_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            en_q     <= en_d;
            ar_q     <= ar_d;
            pend_q   <= pend_d;
        end
    end

    assign count_o   = count_q;
    assign timeout_o = (state_q == EXPIRED);
    assign pending_o = pend_q;
endmodule

module timer_bank #(
    parameter int  DATA_WIDTH = 16,
    parameter int  CHANNELS   = 4,
    parameter int  PRESCALE   = 1,
    localparam int SEL_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] DATA,
    input  logic                  timer_in,
    input  logic                  mode_in,
    input  logic                  ack,
    input  logic [SEL_W-1:0]      ch_select,
    output logic [DATA_WIDTH-1:0] REG_OUT_TIMER,
    output logic [CHANNELS-1:0]   timeout,
    output logic                  irq,
    output logic [SEL_W-1:0]      irq_ch
);
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [PW-1:0]                       psc_q, psc_d;
    logic                                tick;
    logic [CHANNELS-1:0]                 hit;
    logic [CHANNELS-1:0]                 pend;
    logic [CHANNELS-1:0][DATA_WIDTH-1:0] cnt;

    assign tick = (psc_q == PW'(PRESCALE - 1));

    // Free-running prescaler wraps on the tick cycle.
    always_comb begin
        psc_d = tick ? '0 : psc_q + PW'(1);
    end

    // Prescaler register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) psc_q <= '0;
        else        psc_q <= psc_d;
    end

    // Selects beyond CHANNELS-1 match no channel, so those writes fall away.
    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        assign hit[i] = (ch_select == SEL_W'(i));
        timer_bank_ch #(.DATA_WIDTH(DATA_WIDTH)) u_ch (
            .clk       (clk),
            .rst_n     (reset),
            .tick_i    (tick),
            .load_i    (timer_in & hit[i]),
            .mode_i    (mode_in & ~timer_in & hit[i]),
            .ack_i     (ack & hit[i]),
            .data_i    (DATA),
            .count_o   (cnt[i]),
            .timeout_o (timeout[i]),
            .pending_o (pend[i])
        );
    end

    // Readback mux; an unmatched select reads zero.
    always_comb begin
        REG_OUT_TIMER = '0;
        for (int i = 0; i < CHANNELS; i++)
            if (ch_select == SEL_W'(i)) REG_OUT_TIMER = cnt[i];
    end

    // Lowest-numbered pending channel wins.
    always_comb begin
        irq_ch = '0;
        for (int i = CHANNELS - 1; i >= 0; i--)
            if (pend[i]) irq_ch = SEL_W'(i);
    end

    assign irq = |pend;
endmodule
